// File: rtl/encoder_16_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_16_4_pkg
// Description : Shared CPU register-select definitions. Register codes follow
//               the one-hot "Rout" ordering: bit k of a select vector means
//               code k, so R0 sits at bit 15 and R15 at bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_16_4_pkg;

    localparam int SEL_W  = 16;
    localparam int CODE_W = 4;

    // Register codes.
    localparam logic [CODE_W-1:0] R0  = 4'hF;
    localparam logic [CODE_W-1:0] R1  = 4'hE;
    localparam logic [CODE_W-1:0] R2  = 4'hD;
    localparam logic [CODE_W-1:0] R3  = 4'hC;
    localparam logic [CODE_W-1:0] R4  = 4'hB;
    localparam logic [CODE_W-1:0] R5  = 4'hA;
    localparam logic [CODE_W-1:0] R6  = 4'h9;
    localparam logic [CODE_W-1:0] R7  = 4'h8;
    localparam logic [CODE_W-1:0] R8  = 4'h7;
    localparam logic [CODE_W-1:0] R9  = 4'h6;
    localparam logic [CODE_W-1:0] R10 = 4'h5;
    localparam logic [CODE_W-1:0] R11 = 4'h4;
    localparam logic [CODE_W-1:0] R12 = 4'h3;
    localparam logic [CODE_W-1:0] R13 = 4'h2;
    localparam logic [CODE_W-1:0] R14 = 4'h1;
    localparam logic [CODE_W-1:0] R15 = 4'h0;

    // One encoded result: code plus malformed-input flags.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              zero;
        logic              multi;
    } enc_result_t;

endpackage
`default_nettype wire

// File: rtl/prio_enc_16.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_16
// Description : Combinational 16-to-4 priority encoder with zero-hot and
//               multi-hot detection.
//   in_sel  in  16  select vector, bit k -> code k
//   code    out 4   index of the winning set bit (0 when none set)
//   zero    out 1   no bit set
//   multi   out 1   two or more bits set
//   HIGH_WINS       1: highest set bit wins, 0: lowest set bit wins
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_16
    import encoder_16_4_pkg::*;
#(
    parameter int HIGH_WINS = 1
) (
    input  logic [SEL_W-1:0]  in_sel,
    output logic [CODE_W-1:0] code,
    output logic              zero,
    output logic              multi
);

    localparam logic [SEL_W-1:0] c_one = {{(SEL_W-1){1'b0}}, 1'b1};

    assign zero  = ~|in_sel;
    // Clearing the lowest set bit leaves something behind only when at
    // least two bits were set.
    assign multi = |(in_sel & (in_sel - c_one));

    generate
        if (HIGH_WINS != 0) begin : g_high_wins
            // Ascending scan: the last set bit seen is the highest.
            always_comb begin
                code = '0;
                for (int k = 0; k < SEL_W; k++) begin
                    if (in_sel[k]) begin
                        code = CODE_W'(k);
                    end
                end
            end
        end else begin : g_low_wins
            // Descending scan: the last set bit seen is the lowest.
            always_comb begin
                code = '0;
                for (int k = SEL_W - 1; k >= 0; k--) begin
                    if (in_sel[k]) begin
                        code = CODE_W'(k);
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/encoder_16_4.sv
`default_nettype none
// ============================================================================
// Module      : encoder_16_4
// Description : Registered 16-to-4 register-select encoder with valid/ready
//               handshake on both sides and malformed-input accounting.
//   clk         in  1          clock, rising edge
//   clr         in  1          asynchronous active-high reset
//   in_sel      in  16         one-hot select vector
//   in_valid    in  1          in_sel valid
//   in_ready    out 1          encoder can accept this cycle
//   out_code    out 4          encoded register code
//   out_valid   out 1          result held in output register
//   out_ready   in  1          consumer accepts result
//   out_zero    out 1          result came from all-zero in_sel
//   out_multi   out 1          result came from multi-hot in_sel
//   err_sticky  out 1          any malformed input accepted since clear
//   err_count   out ERR_CNT_W  saturating count of malformed accepts
//   err_clr     in  1          synchronous clear of err_sticky/err_count
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_16_4
    import encoder_16_4_pkg::*;
#(
    parameter int HIGH_WINS = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CODE_W-1:0]    out_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_zero,
    output logic                 out_multi,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    localparam logic [ERR_CNT_W-1:0] c_err_one = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};

    enc_result_t          w_enc;
    enc_result_t          r_result;
    logic                 r_out_valid;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 w_accept;
    logic                 w_malformed;

    prio_enc_16 #(
        .HIGH_WINS (HIGH_WINS)
    ) u_prio_enc (
        .in_sel (in_sel),
        .code   (w_enc.code),
        .zero   (w_enc.zero),
        .multi  (w_enc.multi)
    );

    // Ready depends only on the output register state and the consumer, so
    // there is no combinational path from in_valid.
    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_malformed = w_enc.zero || w_enc.multi;

    // Output register. A drain without a new accept only drops valid; the
    // code and flags keep their last values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_result    <= w_enc;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Error accounting. err_clr takes precedence over a same-cycle
    // malformed accept.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_accept && w_malformed) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != c_err_max) begin
                r_err_count <= r_err_count + c_err_one;
            end
        end
    end

    assign out_code   = r_result.code;
    assign out_zero   = r_result.zero;
    assign out_multi  = r_result.multi;
    assign out_valid  = r_out_valid;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_encoder_16_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_16_4
// Description : Scoreboard bench for encoder_16_4. Two instances (highest-
//               wins and lowest-wins) share one stimulus stream; expected
//               results are queued on accept and checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_16_4;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       z;
        logic       m;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] in_sel = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        hi_in_ready, hi_out_valid, hi_out_zero, hi_out_multi, hi_err_sticky;
    logic [3:0]  hi_out_code;
    logic [7:0]  hi_err_count;
    logic        lo_in_ready, lo_out_valid, lo_out_zero, lo_out_multi, lo_err_sticky;
    logic [3:0]  lo_out_code;
    logic [7:0]  lo_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       q[$];
    exp_t       m_last = '0;
    logic       m_sticky = 1'b0;
    logic [7:0] m_count = '0;

    always #5 clk = ~clk;

    encoder_16_4 #(.HIGH_WINS(1), .ERR_CNT_W(8)) dut_hi (
        .clk(clk), .clr(clr), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(hi_in_ready), .out_code(hi_out_code), .out_valid(hi_out_valid),
        .out_ready(out_ready), .out_zero(hi_out_zero), .out_multi(hi_out_multi),
        .err_sticky(hi_err_sticky), .err_count(hi_err_count), .err_clr(err_clr)
    );

    encoder_16_4 #(.HIGH_WINS(0), .ERR_CNT_W(8)) dut_lo (
        .clk(clk), .clr(clr), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(lo_in_ready), .out_code(lo_out_code), .out_valid(lo_out_valid),
        .out_ready(out_ready), .out_zero(lo_out_zero), .out_multi(lo_out_multi),
        .err_sticky(lo_err_sticky), .err_count(lo_err_count), .err_clr(err_clr)
    );

    // Reference: index arithmetic on the select value, not a bit scan.
    function automatic exp_t ref_enc(input logic [15:0] s);
        exp_t        e;
        int unsigned v;
        v   = 32'(s);
        e.z = (s == 16'h0000);
        e.m = ($countones(s) >= 2);
        if (v == 0) begin
            e.hi = 4'h0;
            e.lo = 4'h0;
        end else begin
            e.hi = 4'($clog2(v + 1) - 1);
            e.lo = 4'($clog2(v & (~v + 1)));
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the output register is empty at an edge exactly when the queue
    // is empty (the monitor pops on the preceding negedge when draining).
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_sticky <= 1'b0;
            m_count  <= '0;
        end else begin
            if (in_valid && q.size() == 0) begin
                q.push_back(ref_enc(in_sel));
                if (err_clr) begin
                    m_sticky <= 1'b0;
                    m_count  <= '0;
                end else if (in_sel == 16'h0 || $countones(in_sel) >= 2) begin
                    m_sticky <= 1'b1;
                    if (m_count != 8'hFF) m_count <= m_count + 8'd1;
                end
            end else if (err_clr) begin
                m_sticky <= 1'b0;
                m_count  <= '0;
            end
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (clr) begin
            q.delete();
            m_last = '0;
            check("rst_valid_hi", 32'(hi_out_valid), 0);
            check("rst_valid_lo", 32'(lo_out_valid), 0);
            check("rst_code_hi", 32'(hi_out_code), 0);
            check("rst_code_lo", 32'(lo_out_code), 0);
            check("rst_flags_hi", {30'd0, hi_out_zero, hi_out_multi}, 0);
            check("rst_flags_lo", {30'd0, lo_out_zero, lo_out_multi}, 0);
            check("rst_err_hi", {23'd0, hi_err_sticky, hi_err_count}, 0);
            check("rst_err_lo", {23'd0, lo_err_sticky, lo_err_count}, 0);
            check("rst_in_ready", {30'd0, hi_in_ready, lo_in_ready}, 32'h3);
        end else begin
            check("in_ready_hi", 32'(hi_in_ready), 32'((q.size() == 0) || out_ready));
            check("in_ready_lo", 32'(lo_in_ready), 32'((q.size() == 0) || out_ready));
            check("out_valid_hi", 32'(hi_out_valid), 32'(q.size() != 0));
            check("out_valid_lo", 32'(lo_out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("code_hi", 32'(hi_out_code), 32'(q[0].hi));
                check("code_lo", 32'(lo_out_code), 32'(q[0].lo));
                check("flags_hi", {30'd0, hi_out_zero, hi_out_multi}, {30'd0, q[0].z, q[0].m});
                check("flags_lo", {30'd0, lo_out_zero, lo_out_multi}, {30'd0, q[0].z, q[0].m});
                if (out_ready) m_last = q.pop_front();
            end else begin
                check("hold_code_hi", 32'(hi_out_code), 32'(m_last.hi));
                check("hold_code_lo", 32'(lo_out_code), 32'(m_last.lo));
            end
            check("err_hi", {23'd0, hi_err_sticky, hi_err_count}, {23'd0, m_sticky, m_count});
            check("err_lo", {23'd0, lo_err_sticky, lo_err_count}, {23'd0, m_sticky, m_count});
        end
    end

    task automatic drive(input logic v, input logic [15:0] s, input logic r, input logic ec);
        in_valid  = v;
        in_sel    = s;
        out_ready = r;
        err_clr   = ec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s;
        // Power-on reset.
        repeat (3) drive(1'b1, 16'h0100, 1'b1, 1'b0);
        clr = 1'b0;

        // Build a pending result, then reset asynchronously mid-cycle.
        drive(1'b1, 16'h0104, 1'b0, 1'b0);
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        clr = 1'b1;
        repeat (3) drive(1'b1, 16'h0001, 1'b1, 1'b1);
        clr = 1'b0;

        // Exhaustive one-hot / decoder round trip, full throughput.
        for (int k = 0; k < 16; k++) begin
            s = 16'h0001 << k;
            drive(1'b1, s, 1'b1, 1'b0);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Malformed inputs.
        drive(1'b1, 16'h0000, 1'b1, 1'b0);
        drive(1'b1, 16'h0104, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure.
        drive(1'b1, 16'h0020, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 16'h0400, 1'b0, 1'b0);
        drive(1'b1, 16'h0400, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Saturation, then clear colliding with a multi-hot accept.
        repeat (300) drive(1'b1, 16'h0000, 1'b1, 1'b0);
        drive(1'b1, 16'h0104, 1'b1, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       s = 16'h0000;
                1:       s = 16'h0001 << $urandom_range(0, 15);
                default: s = 16'($urandom);
            endcase
            drive(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
        end
        repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
